// File: rtl/pbkdf2_pkg.sv
// Shared types, widths and the first-message builder for the PBKDF2-HMAC-SHA256 sequencer.
package pbkdf2_pkg;

  localparam int KEY_W      = 512;
  localparam int MSG_W      = 440;
  localparam int PRF_W      = 256;
  localparam int LEN_W      = 5;
  localparam int PRF_HW     = 16;
  localparam int MSG_HW_MAX = 27;
  localparam int SALT_W     = 408;
  localparam int BLK_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // S || INT(blk), left aligned; salt_hw must already be clamped to the salt width.
  function automatic logic [MSG_W-1:0] first_msg(input logic [SALT_W-1:0] salt,
                                                 input logic [LEN_W-1:0]  salt_hw,
                                                 input logic [BLK_W-1:0]  blk);
    logic [8:0]        sh;
    logic [SALT_W-1:0] keep;
    logic [MSG_W-1:0]  blk_pos;
    sh      = {salt_hw, 4'b0000};
    keep    = ~({SALT_W{1'b1}} >> sh);
    blk_pos = {blk, {(MSG_W-BLK_W){1'b0}}} >> sh;
    return {salt & keep, {BLK_W{1'b0}}} | blk_pos;
  endfunction

endpackage

// File: rtl/pbkdf2_accum.sv
// 256-bit XOR accumulator for T = U1 ^ ... ^ Uc with a snapshot register feeding dk.
module pbkdf2_accum
  import pbkdf2_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             acc_en_i,
  input  logic             snap_i,
  input  logic [PRF_W-1:0] prf_i,
  output logic [PRF_W-1:0] dk_o
);

  logic [PRF_W-1:0] acc_q, acc_d;
  logic [PRF_W-1:0] dk_q, dk_d;

  // next accumulator and snapshot values
  always_comb begin
    acc_d = acc_q;
    dk_d  = dk_q;
    if (clr_i) begin
      acc_d = {PRF_W{1'b0}};
    end else if (acc_en_i) begin
      acc_d = acc_q ^ prf_i;
    end else begin
      acc_d = acc_q;
    end
    if (snap_i) begin
      dk_d = acc_q ^ prf_i;
    end else begin
      dk_d = dk_q;
    end
  end

  // accumulator and dk registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= {PRF_W{1'b0}};
      dk_q  <= {PRF_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      dk_q  <= dk_d;
    end
  end

  assign dk_o = dk_q;

endmodule

// File: rtl/pbkdf2_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration sequencer driving one HMAC core for a single output block.
// Optional abort support is built when PBKDF2_CTRL_ABORT_EN is defined.
module pbkdf2_ctrl
  import pbkdf2_pkg::*;
#(
  parameter int ITER_W      = 32,
  parameter int SALT_HW_MAX = 25
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [KEY_W-1:0]  pw_i,
  input  logic [SALT_W-1:0] salt_i,
  input  logic [LEN_W-1:0]  salt_len_i,
  input  logic [BLK_W-1:0]  blk_idx_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic              v_i,
  output logic              r_o,
  output logic [PRF_W-1:0]  dk_o,
  output logic              v_o,
  input  logic              r_i,
`ifdef PBKDF2_CTRL_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic [KEY_W-1:0]  hmac_key_o,
  output logic [MSG_W-1:0]  hmac_msg_o,
  output logic [LEN_W-1:0]  hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [PRF_W-1:0]  hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]  salt_hw_s;
  logic              acc_clr_s, acc_en_s, acc_snap_s;
`ifdef PBKDF2_CTRL_ABORT_EN
  logic              abort_q, abort_d;
  logic              aborted_q, aborted_d;
`endif

  assign salt_hw_s = (salt_len_i > LEN_W'(SALT_HW_MAX)) ? LEN_W'(SALT_HW_MAX) : salt_len_i;

  // next-state and datapath control
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    msg_d      = msg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_clr_s  = 1'b0;
    acc_en_s   = 1'b0;
    acc_snap_s = 1'b0;
`ifdef PBKDF2_CTRL_ABORT_EN
    abort_d    = abort_q;
    aborted_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (v_i) begin
          key_d     = pw_i;
          msg_d     = first_msg(salt_i, salt_hw_s, blk_idx_i);
          len_d     = salt_hw_s + 5'd2;
          cnt_d     = (iter_i == {ITER_W{1'b0}}) ? ITER_W'(1) : iter_i;
          acc_clr_s = 1'b1;
`ifdef PBKDF2_CTRL_ABORT_EN
          abort_d   = 1'b0;
`endif
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // an abort coinciding with acceptance must still collect the started result
        if (hmac_r_i) begin
          state_d = ST_WAIT;
`ifdef PBKDF2_CTRL_ABORT_EN
          abort_d = abort_i;
        end else if (abort_i) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
`endif
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (hmac_v_i) begin
`ifdef PBKDF2_CTRL_ABORT_EN
          if (abort_q || abort_i) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
            abort_d   = 1'b0;
          end else
`endif
          begin
            acc_en_s = 1'b1;
            if (cnt_q != {ITER_W{1'b0}}) begin
              cnt_d = cnt_q - ITER_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
            if (cnt_q == ITER_W'(1)) begin
              acc_snap_s = 1'b1;
              state_d    = ST_DONE;
            end else begin
              msg_d   = {hmac_prf_i, {(MSG_W-PRF_W){1'b0}}};
              len_d   = LEN_W'(PRF_HW);
              state_d = ST_ISSUE;
            end
          end
        end else begin
`ifdef PBKDF2_CTRL_ABORT_EN
          abort_d = abort_q | abort_i;
`endif
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (r_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // controller state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      key_q     <= {KEY_W{1'b0}};
      msg_q     <= {MSG_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      cnt_q     <= {ITER_W{1'b0}};
`ifdef PBKDF2_CTRL_ABORT_EN
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      msg_q     <= msg_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
`ifdef PBKDF2_CTRL_ABORT_EN
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
`endif
    end
  end

  pbkdf2_accum u_accum (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (acc_clr_s),
    .acc_en_i (acc_en_s),
    .snap_i   (acc_snap_s),
    .prf_i    (hmac_prf_i),
    .dk_o     (dk_o)
  );

  assign r_o        = (state_q == ST_IDLE);
  assign v_o        = (state_q == ST_DONE);
  assign hmac_v_o   = (state_q == ST_ISSUE);
  assign hmac_r_o   = (state_q == ST_WAIT) && hmac_v_i;
  assign hmac_key_o = key_q;
  assign hmac_msg_o = msg_q;
  assign hmac_len_o = len_q;
`ifdef PBKDF2_CTRL_ABORT_EN
  assign aborted_o  = aborted_q;
`endif

endmodule

// File: tb/tb_pbkdf2_ctrl.sv
// Bench for pbkdf2_ctrl: behavioural HMAC-SHA256 core, vector table and scoreboard of derived blocks.
// Abort scenario is included when PBKDF2_CTRL_ABORT_EN is defined.
module tb_pbkdf2_ctrl;

  logic         clk;
  logic         rst_n;
  logic [511:0] pw_i;
  logic [407:0] salt_i;
  logic [4:0]   salt_len_i;
  logic [31:0]  blk_idx_i;
  logic [31:0]  iter_i;
  logic         v_i;
  logic         r_o;
  logic [255:0] dk_o;
  logic         v_o;
  logic         r_i;
  logic [511:0] hmac_key_o;
  logic [439:0] hmac_msg_o;
  logic [4:0]   hmac_len_o;
  logic         hmac_v_o;
  logic         hmac_r_i;
  logic [255:0] hmac_prf_i;
  logic         hmac_v_i;
  logic         hmac_r_o;
`ifdef PBKDF2_CTRL_ABORT_EN
  logic         abort_i;
  logic         aborted_o;
`endif

  pbkdf2_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pw_i       (pw_i),
    .salt_i     (salt_i),
    .salt_len_i (salt_len_i),
    .blk_idx_i  (blk_idx_i),
    .iter_i     (iter_i),
    .v_i        (v_i),
    .r_o        (r_o),
    .dk_o       (dk_o),
    .v_o        (v_o),
    .r_i        (r_i),
`ifdef PBKDF2_CTRL_ABORT_EN
    .abort_i    (abort_i),
    .aborted_o  (aborted_o),
`endif
    .hmac_key_o (hmac_key_o),
    .hmac_msg_o (hmac_msg_o),
    .hmac_len_o (hmac_len_o),
    .hmac_v_o   (hmac_v_o),
    .hmac_r_i   (hmac_r_i),
    .hmac_prf_i (hmac_prf_i),
    .hmac_v_i   (hmac_v_i),
    .hmac_r_o   (hmac_r_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] SHA_H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // key is exactly one 64-byte block; message uses only its first len halfwords
  function automatic logic [255:0] hmac_sha256(input logic [511:0] key, input logic [439:0] msg,
                                               input logic [4:0] len);
    logic [511:0] blk;
    logic [255:0] ih;
    int nb;
    nb  = 2 * int'(len);
    blk = {msg, 72'h0};
    for (int i = 0; i < 64; i++) if (i >= nb) blk[511-8*i -: 8] = 8'h00;
    blk[511-8*nb -: 8] = 8'h80;
    blk[63:0] = 64'(512 + 8 * nb);
    ih  = sha_comp(sha_comp(SHA_H0, key ^ {64{8'h36}}), blk);
    blk = {ih, 8'h80, 184'h0, 64'd768};
    return sha_comp(sha_comp(SHA_H0, key ^ {64{8'h5c}}), blk);
  endfunction

  // HMAC core model: accepts while idle, answers two cycles later, holds result until hmac_r_o
  int           acc_total = 0;
  int           cmd_base  = 0;
  logic [4:0]   first_len, second_len;
  logic [439:0] first_msgc;
  logic         core_busy;
  logic [1:0]   core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      core_cnt  <= 2'd0;
      hmac_v_i  <= 1'b0;
      hmac_r_i  <= 1'b1;
    end else if (hmac_v_i) begin
      if (hmac_r_o) begin
        hmac_v_i <= 1'b0;
        hmac_r_i <= 1'b1;
      end
    end else if (core_busy) begin
      if (core_cnt == 2'd0) begin
        hmac_v_i  <= 1'b1;
        core_busy <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 2'd1;
      end
    end else if (hmac_v_o && hmac_r_i) begin
      hmac_prf_i <= hmac_sha256(hmac_key_o, hmac_msg_o, hmac_len_o);
      hmac_r_i   <= 1'b0;
      core_busy  <= 1'b1;
      core_cnt   <= 2'd1;
      acc_total  <= acc_total + 1;
      if (acc_total == cmd_base) begin
        first_len  <= hmac_len_o;
        first_msgc <= hmac_msg_o;
      end
      if (acc_total == cmd_base + 1) second_len <= hmac_len_o;
    end
  end

  typedef struct {
    logic [31:0]  iter;
    logic [255:0] dk;
    int           acc;
  } vec_t;

  typedef struct {
    logic [255:0] dk;
    int           acc;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [255:0] DK_C1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [511:0] PW    = {64'h70617373776f7264, 448'h0};
  localparam logic [407:0] SALT  = {32'h73616c74, 376'h0};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic start_cmd(input logic [407:0] salt, input logic [4:0] slen, input logic [31:0] iter,
                           input bit push, input logic [255:0] exp_dk, input int exp_acc);
    @(negedge clk);
    cmd_base   = acc_total;
    pw_i       = PW;
    salt_i     = salt;
    salt_len_i = slen;
    blk_idx_i  = 32'd1;
    iter_i     = iter;
    v_i        = 1'b1;
    @(negedge clk);
    v_i        = 1'b0;
    pw_i       = ~PW;
    salt_i     = ~salt;
    salt_len_i = 5'd7;
    blk_idx_i  = 32'hdead_beef;
    iter_i     = 32'd9;
    if (push) exp_q.push_back('{exp_dk, exp_acc});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!v_o && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {511'h0, v_o}, 512'h1);
  endtask

  task automatic finish_cmd();
    exp_t e;
    wait_done();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dk", {256'h0, dk_o}, {256'h0, e.dk});
      chk("accept_count", 512'(acc_total - cmd_base), 512'(e.acc));
    end
    r_i = 1'b1;
    @(negedge clk);
    r_i = 1'b0;
    chk("idle_after_release", {510'h0, r_o, v_o}, 512'h2);
  endtask

  vec_t         vecs [4];
  logic [439:0] exp_msg;
  logic [255:0] dk_hold;
  int           n;

  initial begin
    rst_n = 1'b0; pw_i = '0; salt_i = '0; salt_len_i = '0; blk_idx_i = '0;
    iter_i = '0; v_i = 1'b0; r_i = 1'b0;
`ifdef PBKDF2_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    vecs[0] = '{32'd1, DK_C1, 1};
    vecs[1] = '{32'd2, 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43, 2};
    vecs[2] = '{32'd0, DK_C1, 1};
    vecs[3] = '{32'd4096, 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a, 4096};
    exp_msg = {32'h73616c74, 32'h00000001, 376'h0};

    #12;
    chk("rst_flags", {507'h0, r_o, v_o, hmac_v_o, hmac_r_o, 1'b0}, {507'h0, 5'b10000});
    chk("rst_dk", {256'h0, dk_o}, 512'h0);
    chk("rst_core_if", {67'h0, hmac_msg_o, hmac_len_o}, 512'h0);
    chk("rst_key", hmac_key_o, 512'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start_cmd(SALT, 5'd2, vecs[i].iter, 1'b1, vecs[i].dk, vecs[i].acc);
      finish_cmd();
      chk("first_len", {507'h0, first_len}, 512'd4);
      chk("first_msg", {72'h0, first_msgc}, {72'h0, exp_msg});
      if (vecs[i].acc >= 2) chk("second_len", {507'h0, second_len}, 512'd16);
    end

    // results held while r_i is low; commands offered during DONE are ignored
    start_cmd(SALT, 5'd2, 32'd0, 1'b1, DK_C1, 1);
    wait_done();
    dk_hold = dk_o;
    v_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("done_hold", {254'h0, v_o, r_o, dk_o}, {254'h0, 1'b1, 1'b0, dk_hold});
    end
    v_i = 1'b0;
    finish_cmd();
    chk("dk_kept_in_idle", {256'h0, dk_o}, {256'h0, DK_C1});

    // over-long salt length is clamped to 25 halfwords
    start_cmd({408{1'b1}}, 5'd31, 32'd1, 1'b0, 256'h0, 0);
    finish_cmd();
    chk("clamp_len", {507'h0, first_len}, 512'd27);
    chk("clamp_msg", {72'h0, first_msgc}, {72'h0, {400{1'b1}}, 32'h1, 8'h0});

    // asynchronous reset in WAIT of the third iteration
    start_cmd(SALT, 5'd2, 32'd4096, 1'b0, 256'h0, 0);
    n = 0;
    while (acc_total - cmd_base < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_wait_iter3", {510'h0, hmac_v_o, 1'b1}, 512'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {509'h0, r_o, hmac_v_o, v_o}, 512'h4);
    @(negedge clk);
    rst_n = 1'b1;
    start_cmd(SALT, 5'd2, 32'd1, 1'b1, DK_C1, 1);
    finish_cmd();

`ifdef PBKDF2_CTRL_ABORT_EN
    begin
      int r_cnt, ab_cnt, v_cnt;
      r_cnt = 0; ab_cnt = 0; v_cnt = 0;
      dk_hold = dk_o;
      start_cmd(SALT, 5'd2, 32'd4096, 1'b0, 256'h0, 0);
      n = 0;
      while (acc_total - cmd_base < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      abort_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (hmac_r_o) r_cnt++;
        if (aborted_o) ab_cnt++;
        if (v_o) v_cnt++;
        @(negedge clk);
        abort_i = 1'b0;
      end
      chk("abort_r_pulses", 512'(r_cnt), 512'd1);
      chk("abort_flag_pulses", 512'(ab_cnt), 512'd1);
      chk("abort_no_result", 512'(v_cnt), 512'd0);
      chk("abort_idle_dk", {255'h0, r_o, dk_o}, {255'h0, 1'b1, dk_hold});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
